sbox_pipeline: RTL and testbench
================================

Name: sbox_pipeline

Overview:
- Three-stage pipelined AES S-box built on composite-field GF(((2^2)^2)^2) arithmetic.
- Sits between the SubBytes byte sequencer and the ShiftRows buffer. Accepts one byte per cycle under a valid/ready handshake.
- Applies the forward S-box (encrypt) or inverse S-box (decrypt) according to a per-byte mode bit.
- Carries a sideband tag so downstream logic can restore byte position.

Parameters:
- TAG_W, 4, width of the sideband tag carried alongside each byte (state byte index 0-15).
- ENABLE_INV, 1, when 0 the inverse-affine/decrypt path is removed and in_mode is ignored (treated as 0).

Ports:
- clk  input  1  single clock for the whole block.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous clear of all stage valids.
- in_valid  input  1  upstream byte valid.
- in_ready  output  1  block can accept a byte this cycle.
- in_data  input  8  byte to substitute.
- in_mode  input  1  0 = forward S-box, 1 = inverse S-box.
- in_tag  input  TAG_W  sideband tag.
- out_valid  output  1  substituted byte valid.
- out_ready  input  1  downstream accepts the byte.
- out_data  output  8  substituted byte.
- out_tag  output  TAG_W  tag of out_data.

Behaviour:
- Reset (rst_n low, asynchronous): all stage valids = 0. out_valid=0, out_data=8'h00, out_tag=0. Stage data registers are cleared to 0.
- in_ready is 1 during reset deassertion once the pipe is empty.
- Transfer rules:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
- Stage S1 captures these registers:
  - mode and tag.
  - The isomorphic map of x into GF((2^4)^2), split into high nibble ah and low nibble al. For decrypt, x is first the inverse affine of in_data ((x<<<1)^(x<<<3)^(x<<<6)^8'h05); for encrypt, x = in_data.
- Stage S2 captures these registers:
  - ah, al, mode and tag.
  - dinv = inverse in GF(2^4) of d = λ·ah² ⊕ ah·al ⊕ al². GF(2^4) squaring and multiplication are built from GF(2^2) square/multiply/scale primitives.
- Stage S3 is the output register and captures:
  - y = inverse isomorphic map of (ah·dinv, (ah⊕al)·dinv).
  - For encrypt, y then goes through the forward affine (b^(b<<<1)^(b<<<2)^(b<<<3)^(b<<<4)^8'h63). For decrypt, y is output directly.
  - out_data and out_tag.
- Zero handling: input 0 maps to inverse 0 (d=0 → dinv=0), with no special-casing.
- Latency: exactly 3 cycles from input transfer to out_valid when out_ready stays 1. Throughput is 1 byte/cycle.
- Backpressure:
  - Each stage k advances when stage k is valid and (stage k+1 is empty or stage k+1 advances). S3 advances on out_ready.
  - in_ready = !S1.valid || S1 advances. This is combinational from out_ready through the chain.
  - Stalled stages hold data and tag unchanged. out_data and out_tag must be stable while out_valid && !out_ready.
- Bubbles: an empty stage is filled whenever the prior stage is valid, even if later stages are stalled. Four bytes can be outstanding only as 3 in the pipe plus 1 waiting at the input.
- flush:
  - Clears all valids on the next edge and overrides any input transfer in that cycle.
  - out_valid=0 the following cycle.
  - Data registers are left as-is.
- Reset mid-operation: all in-flight bytes are discarded and no output is produced for them.
- Ordering: strictly in-order. The tag is never reordered or altered.

Decomposition:
- Package sbox_pkg holds:
  - Typedefs gf4_t (4-bit) and gf2_t (2-bit).
  - Constants: isomorphic-map and inverse-map 8x8 matrices, λ and φ constants, affine constant 8'h63, inverse-affine constant 8'h05.
  - Functions for the affine and inverse affine transforms.
- One combinational sub-module, gf2_4_inverse: 4-bit in, 4-bit out, composed of the existing GF(2^2) primitives.
- GF(2^4) multiply is a package function.

Test Plan:
- Encrypt singles with out_ready=1: send 8'h00, 8'h01, 8'h53 with mode=0 → out_data 8'h63, 8'h7C, 8'hED appear exactly 3 cycles after each input.
- Decrypt singles: send 8'h63, 8'h7C, 8'hED with mode=1 → out_data 8'h00, 8'h01, 8'h53.
- Exhaustive back-to-back: stream all 256 values, encrypt then decrypt, with tags cycling 0-15 → outputs match a reference table one per cycle, tags in order, no gaps.
- Backpressure: stream 8 bytes with out_ready toggled randomly and held low 5 cycles:
  - in_ready drops after the pipe plus input fill.
  - out_data is stable during stalls.
  - No bytes are lost or duplicated, and order is preserved.
- flush: while 3 bytes are in flight, pulse flush with in_valid=1 → no outputs for those bytes, the flushed-cycle input is not accepted, and the next byte 8'h53 (mode 0) produces 8'hED 3 cycles later.
- Async reset: assert rst_n low mid-stream off a clock edge → out_valid=0 and out_data=8'h00 immediately. After release, the first new byte produces correct output with latency 3.

Source files
------------

// File: rtl/sbox_pkg.sv
// AES S-box composite-field helpers: GF(2^2)/GF(2^4) arithmetic over
// GF(((2^2)^2)^2), basis-change matrices and the AES affine transforms.
package sbox_pkg;

  typedef logic [3:0] gf4_t;
  typedef logic [1:0] gf2_t;

  // Basis-change matrices. Byte i of each constant is the row for output
  // bit i: that output bit is the parity of (row & input).
  localparam logic [63:0] ISO_MAP = 64'hA0DE_ACAE_C69E_5243;
  localparam logic [63:0] INV_MAP = 64'hE244_6276_3E9E_3075;

  // GF(2^4) = GF(2^2)[x]/(x^2+x+PHI), GF(2^8) = GF(2^4)[x]/(x^2+x+LAMBDA)
  localparam gf4_t LAMBDA = 4'hC;
  localparam gf2_t PHI    = 2'b10;

  localparam logic [7:0] AFFINE_C     = 8'h63;
  localparam logic [7:0] INV_AFFINE_C = 8'h05;

  function automatic logic [7:0] mat_mul8(input logic [63:0] m, input logic [7:0] x);
    logic [7:0] y;
    y = 8'h00;
    for (int i = 0; i < 8; i++) y[i] = ^(m[8*i +: 8] & x);
    return y;
  endfunction

  // GF(2^2) over x^2+x+1
  function automatic gf2_t gf2_mul(input gf2_t a, input gf2_t b);
    gf2_t r;
    r[1] = (a[1] & b[1]) ^ (a[0] & b[1]) ^ (a[1] & b[0]);
    r[0] = (a[1] & b[1]) ^ (a[0] & b[0]);
    return r;
  endfunction

  // Squaring in GF(2^2) is also its multiplicative inverse.
  function automatic gf2_t gf2_sq(input gf2_t a);
    return {a[1], a[1] ^ a[0]};
  endfunction

  function automatic gf4_t gf4_mul(input gf4_t a, input gf4_t b);
    gf2_t hh, hl, lh, ll;
    hh = gf2_mul(a[3:2], b[3:2]);
    hl = gf2_mul(a[3:2], b[1:0]);
    lh = gf2_mul(a[1:0], b[3:2]);
    ll = gf2_mul(a[1:0], b[1:0]);
    return {hh ^ hl ^ lh, gf2_mul(hh, PHI) ^ ll};
  endfunction

  function automatic gf4_t gf4_sq(input gf4_t a);
    gf2_t h2, l2;
    h2 = gf2_sq(a[3:2]);
    l2 = gf2_sq(a[1:0]);
    return {h2, gf2_mul(h2, PHI) ^ l2};
  endfunction

  function automatic logic [7:0] affine_fwd(input logic [7:0] b);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
             ^ {b[3:0], b[7:4]} ^ AFFINE_C;
  endfunction

  function automatic logic [7:0] affine_inv(input logic [7:0] x);
    return {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ INV_AFFINE_C;
  endfunction

endpackage

// File: rtl/sbox_pipeline_gf2_4_inverse.sv
// Combinational GF(2^4) inverse built from GF(2^2) primitives.
// Zero maps to zero naturally (d = 0 gives a zero result).
module gf2_4_inverse
  import sbox_pkg::*;
(
  input  gf4_t a,
  output gf4_t a_inv
);

  gf2_t h, l, d, d_inv;

  assign h     = a[3:2];
  assign l     = a[1:0];
  assign d     = gf2_mul(gf2_sq(h), PHI) ^ gf2_mul(h, l) ^ gf2_sq(l);
  assign d_inv = gf2_sq(d);
  assign a_inv = {gf2_mul(h, d_inv), gf2_mul(h ^ l, d_inv)};

endmodule

// File: rtl/sbox_pipeline.sv
// Three-stage AES S-box (forward/inverse per byte) with valid/ready flow
// control and a sideband tag that travels with each byte.
module sbox_pipeline
  import sbox_pkg::*;
#(
  parameter int TAG_W      = 4,
  parameter bit ENABLE_INV = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  input  logic             in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic [TAG_W-1:0] out_tag
);

  logic             s1_valid_reg, s1_mode_reg;
  logic [TAG_W-1:0] s1_tag_reg;
  gf4_t             s1_ah_reg, s1_al_reg;

  logic             s2_valid_reg, s2_mode_reg;
  logic [TAG_W-1:0] s2_tag_reg;
  gf4_t             s2_ah_reg, s2_al_reg, s2_dinv_reg;

  logic       adv1, adv2, adv3;
  logic       in_fire, s2_load, s3_load;
  logic       mode_eff;
  logic [7:0] x_pre, x_iso;
  gf4_t       d, dinv;
  logic [7:0] y_iso, y_lin, y_out;

  // Advance chain: a stage moves when the next one is empty or moving.
  assign adv3     = out_valid & out_ready;
  assign adv2     = s2_valid_reg & (~out_valid | adv3);
  assign adv1     = s1_valid_reg & (~s2_valid_reg | adv2);
  assign in_ready = ~s1_valid_reg | adv1;
  assign in_fire  = in_valid & in_ready & ~flush;
  assign s2_load  = adv1 & ~flush;
  assign s3_load  = adv2 & ~flush;

  // Decrypt bytes are pre-processed by the inverse affine before inversion.
  generate
    if (ENABLE_INV) begin : g_inv_front
      assign mode_eff = in_mode;
      assign x_pre    = in_mode ? affine_inv(in_data) : in_data;
    end else begin : g_fwd_front
      assign mode_eff = 1'b0;
      assign x_pre    = in_data;
    end
  endgenerate

  assign x_iso = mat_mul8(ISO_MAP, x_pre);

  // Norm of the GF((2^4)^2) element, inverted in GF(2^4).
  assign d = gf4_mul(gf4_sq(s1_ah_reg), LAMBDA) ^ gf4_mul(s1_ah_reg, s1_al_reg)
           ^ gf4_sq(s1_al_reg);

  gf2_4_inverse u_inv (
    .a     (d),
    .a_inv (dinv)
  );

  assign y_iso = {gf4_mul(s2_ah_reg, s2_dinv_reg),
                  gf4_mul(s2_ah_reg ^ s2_al_reg, s2_dinv_reg)};
  assign y_lin = mat_mul8(INV_MAP, y_iso);

  // Encrypt bytes finish with the forward affine; decrypt bytes leave as-is.
  generate
    if (ENABLE_INV) begin : g_inv_back
      assign y_out = s2_mode_reg ? y_lin : affine_fwd(y_lin);
    end else begin : g_fwd_back
      assign y_out = affine_fwd(y_lin);
    end
  endgenerate

  // Stage 1: capture mode, tag and the isomorphic image of the input byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg <= 1'b0;
      s1_mode_reg  <= 1'b0;
      s1_tag_reg   <= '0;
      s1_ah_reg    <= '0;
      s1_al_reg    <= '0;
    end else begin
      if (flush)        s1_valid_reg <= 1'b0;
      else if (in_fire) s1_valid_reg <= 1'b1;
      else if (adv1)    s1_valid_reg <= 1'b0;
      if (in_fire) begin
        s1_mode_reg <= mode_eff;
        s1_tag_reg  <= in_tag;
        s1_ah_reg   <= x_iso[7:4];
        s1_al_reg   <= x_iso[3:0];
      end
    end
  end

  // Stage 2: carry the nibbles forward together with the inverted norm.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_reg <= 1'b0;
      s2_mode_reg  <= 1'b0;
      s2_tag_reg   <= '0;
      s2_ah_reg    <= '0;
      s2_al_reg    <= '0;
      s2_dinv_reg  <= '0;
    end else begin
      if (flush)     s2_valid_reg <= 1'b0;
      else if (adv1) s2_valid_reg <= 1'b1;
      else if (adv2) s2_valid_reg <= 1'b0;
      if (s2_load) begin
        s2_mode_reg <= s1_mode_reg;
        s2_tag_reg  <= s1_tag_reg;
        s2_ah_reg   <= s1_ah_reg;
        s2_al_reg   <= s1_al_reg;
        s2_dinv_reg <= dinv;
      end
    end
  end

  // Stage 3: output register; holds steady while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= 8'h00;
      out_tag   <= '0;
    end else begin
      if (flush)     out_valid <= 1'b0;
      else if (adv2) out_valid <= 1'b1;
      else if (adv3) out_valid <= 1'b0;
      if (s3_load) begin
        out_data <= y_out;
        out_tag  <= s2_tag_reg;
      end
    end
  end

endmodule

// File: tb/tb_sbox_pipeline.sv
// Randomised bench for sbox_pipeline against a GF(2^8) reference model.
module tb_sbox_pipeline;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       flush = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'h00;
  logic       in_mode = 1'b0;
  logic [3:0] in_tag = 4'h0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_data;
  logic [3:0] out_tag;

  always #5 clk = ~clk;

  sbox_pipeline #(.TAG_W(4), .ENABLE_INV(1'b1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag)
  );

  int n_err = 0;
  int n_chk = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model: plain GF(2^8) arithmetic ----------------
  logic [7:0] sb [256];
  logic [7:0] isb [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] c;
    if (a == 8'h00) return 8'h00;
    for (int k = 1; k < 256; k++) begin
      c = k[7:0];
      if (gmul(a, c) == 8'h01) return c;
    end
    return 8'h00;
  endfunction

  function automatic logic [7:0] ref_affine(input logic [7:0] b);
    logic [7:0] r;
    logic [7:0] c;
    c = 8'h63;
    r = 8'h00;
    for (int i = 0; i < 8; i++)
      r[i] = b[i] ^ b[(i+4)%8] ^ b[(i+5)%8] ^ b[(i+6)%8] ^ b[(i+7)%8] ^ c[i];
    return r;
  endfunction

  task automatic build_tables();
    logic [7:0] v;
    for (int i = 0; i < 256; i++) begin
      v = ref_affine(ginv(i[7:0]));
      sb[i]  = v;
      isb[v] = i[7:0];
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  typedef struct {
    logic [7:0] d;
    logic [3:0] t;
    int         c;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       e;
  int         cyc = 0;
  bit         lat_chk = 1'b1;
  int         out_count = 0;
  logic [7:0] last_out = 8'h00;
  bit         prev_stall = 1'b0;
  bit         prev_flush = 1'b0;
  logic [7:0] prev_d = 8'h00;
  logic [3:0] prev_t = 4'h0;
  int         ready_mode = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        prev_stall = 1'b0;
        prev_flush = 1'b0;
      end else begin
        if (prev_flush) chk("flush_clears_out_valid", out_valid, 1'b0);
        if (prev_stall && !prev_flush) begin
          chk("stall_valid", out_valid, 1'b1);
          chk("stall_data", out_data, prev_d);
          chk("stall_tag", out_tag, prev_t);
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_out", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("out_data", out_data, e.d);
            chk("out_tag", out_tag, e.t);
            if (lat_chk) chk("latency", cyc - e.c, 3);
          end
          out_count++;
          last_out = out_data;
          $display("out tag=%0d data=%02h cycle=%0d", out_tag, out_data, cyc);
        end
        if (flush) begin
          exp_q.delete();
        end else if (in_valid && in_ready) begin
          e.d = in_mode ? isb[in_data] : sb[in_data];
          e.t = in_tag;
          e.c = cyc;
          exp_q.push_back(e);
        end
        prev_stall = out_valid && !out_ready;
        prev_d     = out_data;
        prev_t     = out_tag;
        prev_flush = flush;
      end
      cyc++;
    end
  end

  // Downstream ready driver: always high, random, or held low.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [7:0] d, input logic m, input logic [3:0] t);
    bit acc;
    acc      = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_mode  = m;
    in_tag   = t;
    for (int k = 0; k < 300 && !acc; k++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    if (!acc) chk("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input int start);
    for (int k = 0; k < 50 && out_count == start; k++) @(posedge clk);
    #1;
    chk("out_seen", out_count != start, 1);
  endtask

  task automatic single(input string name, input logic [7:0] d, input logic m,
                        input logic [3:0] t, input logic [7:0] expd);
    int start;
    start = out_count;
    send(d, m, t);
    wait_out(start);
    chk(name, last_out, expd);
  endtask

  task automatic drain();
    for (int k = 0; k < 2000 && exp_q.size() != 0; k++) @(posedge clk);
    #1;
    chk("drain_empty", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic flush_pulse();
    in_valid = 1'b1;
    in_data  = 8'hAA;
    in_mode  = 1'b0;
    in_tag   = 4'hF;
    flush    = 1'b1;
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int start;
    build_tables();

    // Power-on reset
    #1 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 8'h00);
    chk("rst_out_tag", out_tag, 4'h0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_idle_valid", out_valid, 1'b0);

    // Directed singles
    single("enc_00", 8'h00, 1'b0, 4'h1, 8'h63);
    single("enc_01", 8'h01, 1'b0, 4'h2, 8'h7C);
    single("enc_53", 8'h53, 1'b0, 4'h3, 8'hED);
    single("dec_63", 8'h63, 1'b1, 4'h4, 8'h00);
    single("dec_7c", 8'h7C, 1'b1, 4'h5, 8'h01);
    single("dec_ed", 8'hED, 1'b1, 4'h6, 8'h53);
    drain();

    // Exhaustive back-to-back, encrypt then decrypt
    start = out_count;
    for (int i = 0; i < 256; i++) send(i[7:0], 1'b0, i[3:0]);
    for (int i = 0; i < 256; i++) send(i[7:0], 1'b1, i[3:0]);
    drain();
    chk("exhaustive_count", out_count - start, 512);

    // Backpressure: hold low, then random
    lat_chk    = 1'b0;
    ready_mode = 2;
    start      = out_count;
    fork
      begin
        for (int i = 0; i < 8; i++) send(8'($urandom), 1'($urandom), i[3:0]);
      end
      begin
        repeat (6) @(negedge clk);
        #1;
        chk("bp_in_ready_low", in_ready, 1'b0);
        chk("bp_pipe_full", out_valid, 1'b1);
        ready_mode = 1;
      end
    join
    drain();
    chk("bp_count", out_count - start, 8);

    // Random traffic with idle gaps and random backpressure
    start = out_count;
    for (int i = 0; i < 60; i++) begin
      send(8'($urandom), 1'($urandom), 4'($urandom));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    ready_mode = 0;
    drain();
    chk("rand_count", out_count - start, 60);

    // Flush with a full stalled pipe
    ready_mode = 2;
    @(posedge clk);
    #1;
    send(8'h11, 1'b0, 4'h1);
    send(8'h22, 1'b0, 4'h2);
    send(8'h33, 1'b1, 4'h3);
    flush_pulse();
    ready_mode = 0;
    start = out_count;
    repeat (6) @(posedge clk);
    #1;
    chk("flush_full_no_out", out_count - start, 0);

    // Flush while input would otherwise be accepted
    lat_chk = 1'b1;
    send(8'h44, 1'b0, 4'h4);
    send(8'h55, 1'b0, 4'h5);
    flush_pulse();
    start = out_count;
    repeat (6) @(posedge clk);
    #1;
    chk("flush_open_no_out", out_count - start, 0);
    single("post_flush_53", 8'h53, 1'b0, 4'h7, 8'hED);
    drain();

    // Asynchronous reset mid-stream
    send(8'h01, 1'b0, 4'h8);
    send(8'h02, 1'b0, 4'h9);
    send(8'h03, 1'b0, 4'hA);
    chk("pre_rst_valid", out_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", out_valid, 1'b0);
    chk("async_rst_data", out_data, 8'h00);
    chk("async_rst_tag", out_tag, 4'h0);
    repeat (2) @(posedge clk);
    #4 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", in_ready, 1'b1);
    chk("post_rst_idle", out_valid, 1'b0);
    single("post_rst_53", 8'h53, 1'b0, 4'hB, 8'hED);
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
